// File: rtl/draw_sequencer.sv
// Draw controller for the VGA plot path: optional screen clear, then one shape draw.
// Owns the shared VGA bus, clips off-screen plots and watchdogs each engine handshake.
module draw_sequencer #(
  parameter int unsigned SCREEN_W       = 160,
  parameter int unsigned SCREEN_H       = 120,
  parameter logic [2:0]  FILL_COLOUR    = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic       clk,
  input  logic       rst_n,
  // Request side
  input  logic       start,
  input  logic       clear_en,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  output logic       done,
  output logic       error,
  // Fillscreen engine
  output logic       fill_start,
  output logic [2:0] fill_colour,
  input  logic       fill_done,
  input  logic [7:0] fill_x,
  input  logic [6:0] fill_y,
  input  logic [2:0] fill_pcol,
  input  logic       fill_plot,
  // Shape engine
  output logic       shp_start,
  output logic [2:0] shp_colour,
  output logic [7:0] shp_centre_x,
  output logic [6:0] shp_centre_y,
  output logic [7:0] shp_diameter,
  input  logic       shp_done,
  input  logic [7:0] shp_x,
  input  logic [6:0] shp_y,
  input  logic [2:0] shp_pcol,
  input  logic       shp_plot,
  // Arbitrated VGA bus
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    X_LIM     = 9'(SCREEN_W);
  localparam logic [7:0]    Y_LIM     = 8'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FILL_REL,
    S_SHAPE,
    S_SHAPE_REL,
    S_FIN,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] diameter;
  } params_t;

  state_t        state_q, state_d;
  params_t       params_q, params_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fill_start_q, fill_start_d;
  logic          shp_start_q, shp_start_d;
  logic          waiting;
  logic          timeout;

  assign waiting = (state_q == S_FILL) || (state_q == S_FILL_REL) ||
                   (state_q == S_SHAPE) || (state_q == S_SHAPE_REL);
  assign timeout = (timer_q == TIMER_MAX);

  // Handshake exits are tested before the watchdog so a same-cycle exit wins.
  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    params_d = params_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          params_d.colour   = colour;
          params_d.centre_x = centre_x;
          params_d.centre_y = centre_y;
          params_d.diameter = diameter;
          state_d           = clear_en ? S_FILL : S_SHAPE;
        end
      end
      S_FILL: begin
        if (fill_done)    state_d = S_FILL_REL;
        else if (timeout) state_d = S_ERR;
      end
      S_FILL_REL: begin
        if (!fill_done)   state_d = S_SHAPE;
        else if (timeout) state_d = S_ERR;
      end
      S_SHAPE: begin
        if (shp_done)     state_d = S_SHAPE_REL;
        else if (timeout) state_d = S_ERR;
      end
      S_SHAPE_REL: begin
        if (!shp_done)    state_d = S_FIN;
        else if (timeout) state_d = S_ERR;
      end
      S_FIN, S_ERR: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || !waiting) timer_d = '0;
    else                                  timer_d = timer_q + 1'b1;

    // Starts rise one cycle after entry and drop on the edge that leaves the state.
    fill_start_d = (state_q == S_FILL)  && (state_d == S_FILL);
    shp_start_d  = (state_q == S_SHAPE) && (state_d == S_SHAPE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      params_q     <= '0;
      timer_q      <= '0;
      fill_start_q <= 1'b0;
      shp_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      params_q     <= params_d;
      timer_q      <= timer_d;
      fill_start_q <= fill_start_d;
      shp_start_q  <= shp_start_d;
    end
  end

  assign done         = (state_q == S_FIN) || (state_q == S_ERR);
  assign error        = (state_q == S_ERR);
  assign fill_start   = fill_start_q;
  assign fill_colour  = FILL_COLOUR;
  assign shp_start    = shp_start_q;
  assign shp_colour   = params_q.colour;
  assign shp_centre_x = params_q.centre_x;
  assign shp_centre_y = params_q.centre_y;
  assign shp_diameter = params_q.diameter;

  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_col;
  logic       sel_plot;

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    sel_plot = 1'b0;
    case (state_q)
      S_FILL, S_FILL_REL: begin
        sel_x    = fill_x;
        sel_y    = fill_y;
        sel_col  = fill_pcol;
        sel_plot = fill_plot;
      end
      S_SHAPE, S_SHAPE_REL: begin
        sel_x    = shp_x;
        sel_y    = shp_y;
        sel_col  = shp_pcol;
        sel_plot = shp_plot;
      end
      default: ;
    endcase
  end

  assign vga_x      = sel_x;
  assign vga_y      = sel_y;
  assign vga_colour = sel_col;
  assign vga_plot   = sel_plot && ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

endmodule
